excess3_to_bcd_deser: RTL and testbench
=======================================

Name: excess3_to_bcd_deser

Overview:
- Receive-side counterpart of the BCD-to-Excess-3 encoder. Accepts a serial stream of Excess-3 digits, one per handshake, most significant digit first.
- Decodes each digit to BCD, flags illegal codes, and packs NUM_DIGITS digits into one parallel BCD word.
- Presents the packed word on a valid/ready output port to downstream display or arithmetic logic.

Parameters:
- NUM_DIGITS, 4, number of decimal digits packed per output word (legal range 1..8).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_digit carries a digit this cycle.
- in_ready  output  1  block can accept a digit this cycle.
- in_digit  input  4  Excess-3 coded digit.
- out_valid  output  1  out_bcd, out_err and out_err_mask hold a complete word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_bcd  output  4*NUM_DIGITS  packed BCD word; nibble NUM_DIGITS-1 holds the first digit received.
- out_err  output  1  OR-reduction of out_err_mask.
- out_err_mask  output  NUM_DIGITS  bit i set = nibble i came from an illegal code.

Behaviour:
- Reset: rst_n sampled low at a clk edge sets the following. State COLLECT, digit count 0, out_valid=0, out_bcd=0, out_err=0, out_err_mask=0. in_ready is 1 from the first cycle after reset.
- Reset mid-word: any partially collected digits are discarded; no word is emitted.
- Per-digit decode:
  - Legal codes 4'h3..4'hC decode to in_digit-3 (modulo-16 arithmetic, 4 bits).
  - Illegal codes 4'h0..4'h2 and 4'hD..4'hF decode to 4'hF; the matching mask bit is set.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready. On accept, the decoded nibble is written at index NUM_DIGITS-1-count and count increments.
  - in_valid low holds state; gaps of any length are legal.
  - When the accepted digit is digit number NUM_DIGITS, count returns to 0 and the next state is HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_bcd, out_err and out_err_mask are stable until the handshake.
  - out_valid && out_ready returns the block to COLLECT on the next cycle.
  - out_ready low holds HOLD indefinitely.
- Latency and throughput:
  - out_valid rises in the cycle after the last digit is accepted.
  - Peak throughput is one word per NUM_DIGITS+1 cycles. There is no overlap of HOLD and COLLECT.
- Output registers:
  - Output data is registered and is not cleared on handshake.
  - The next word's nibbles overwrite the registers as each digit is accepted.
  - out_err_mask is cleared on the first accept of a new word.
  - Data is only meaningful while out_valid=1.
- Simultaneous events:
  - rst_n low overrides any handshake in the same cycle.
  - in_valid is ignored in HOLD.
- No combinational path from in_valid or out_ready to any output.

Decomposition:
- Package excess3_pkg holds:
  - constants X3_OFFSET=4'd3, X3_MIN=4'h3, X3_MAX=4'hC, BCD_ILLEGAL=4'hF;
  - the state enum {COLLECT, HOLD};
  - the decode function shared with the encoder's bench.
- Sub-module x3_digit_decode (combinational):
  - input: 4-bit Excess-3 digit;
  - outputs: 4-bit BCD and 1-bit illegal flag.
- The top module holds the FSM, the counter and the packing registers.

Test Plan:
1. Reset, then in_digit 4'h4,4'h8,4'hC,4'h3 on consecutive cycles with out_ready=1 -> out_valid=1 in cycle 5 for exactly one cycle; out_bcd=16'h1590, out_err=0, out_err_mask=4'b0000.
2. in_digit 4'h3,4'h0,4'h6,4'hD -> out_bcd=16'h0F3F, out_err_mask=4'b0101, out_err=1.
3. Word 4'h5,4'h6,4'h7,4'h8 with out_ready=0 for 6 cycles -> out_valid stays 1, out_bcd=16'h2345 stable, in_ready=0, extra in_valid pulses ignored. Raise out_ready -> in_ready=1 the next cycle.
4. Feed 4'h9,4'h9 then pull rst_n low one cycle, then feed 4'h4,4'h4,4'h4,4'h4 -> single word out_bcd=16'h1111; no word contains 6.
5. in_valid toggled 1,0,0,1,0,1,1 carrying 4'hC,x,x,4'hB,x,4'hA,4'h9 -> out_bcd=16'h9876, out_valid one cycle after the final accept.
6. Sweep all 16 codes across four words -> codes 3..C map to BCD 0..9; the other six codes give 4'hF with the matching mask bits set.

Source files
------------

// File: rtl/excess3_pkg.sv
// Shared Excess-3 definitions: code range constants, deserializer state
// encoding and the per-digit decode function.
package excess3_pkg;

    localparam logic [3:0] X3_OFFSET   = 4'd3;
    localparam logic [3:0] X3_MIN      = 4'h3;
    localparam logic [3:0] X3_MAX      = 4'hC;
    localparam logic [3:0] BCD_ILLEGAL = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] bcd;
    } x3_dec_t;

    // Codes outside 3..C have no decimal meaning and map to a marker nibble.
    function automatic x3_dec_t x3_decode(input logic [3:0] code);
        x3_dec_t r;
        if ((code >= X3_MIN) && (code <= X3_MAX)) begin
            r.illegal = 1'b0;
            r.bcd     = code - X3_OFFSET;
        end else begin
            r.illegal = 1'b1;
            r.bcd     = BCD_ILLEGAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/x3_digit_decode.sv
// Combinational Excess-3 to BCD digit decoder with illegal-code flag.
module x3_digit_decode
    import excess3_pkg::*;
(
    input  logic [3:0] x3_digit,
    output logic [3:0] bcd_digit,
    output logic       illegal
);

    x3_dec_t dec;

    assign dec       = x3_decode(x3_digit);
    assign bcd_digit = dec.bcd;
    assign illegal   = dec.illegal;

endmodule

// File: rtl/excess3_to_bcd_deser.sv
// Serial Excess-3 digit receiver: decodes each digit, packs NUM_DIGITS of
// them MSD-first into a BCD word and holds it on a valid/ready output.
module excess3_to_bcd_deser
    import excess3_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_digit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_err,
    output logic [NUM_DIGITS-1:0]   out_err_mask
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;

    logic [3:0] dec_bcd;
    logic       dec_illegal;
    logic       accept;

    x3_digit_decode u_decode (
        .x3_digit  (in_digit),
        .bcd_digit (dec_bcd),
        .illegal   (dec_illegal)
    );

    assign accept = in_valid && (state_q == COLLECT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        mask_d  = mask_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    // Stale error bits from the previous word go on the first digit.
                    if (count_q == '0) begin
                        mask_d = '0;
                    end
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if ((LAST_IDX - count_q) == CNT_W'(i)) begin
                            bcd_d[4*i +: 4] = dec_bcd;
                            mask_d[i]       = dec_illegal;
                        end
                    end
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            bcd_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            mask_q  <= mask_d;
        end
    end

    assign in_ready     = (state_q == COLLECT);
    assign out_valid    = (state_q == HOLD);
    assign out_bcd      = bcd_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

endmodule

// File: tb/tb_excess3_to_bcd_deser.sv
// Bench for excess3_to_bcd_deser: directed words plus random traffic checked
// against a word-level model of the receiver.
module tb_excess3_to_bcd_deser;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_digit;
    logic           out_valid;
    logic           out_ready;
    logic [4*N-1:0] out_bcd;
    logic           out_err;
    logic [N-1:0]   out_err_mask;

    int n_total = 0;
    int n_pass  = 0;

    bit             exp_hold;
    logic [4*N-1:0] exp_bcd;
    logic [N-1:0]   exp_mask;
    logic [3:0]     acc_q[$];

    excess3_to_bcd_deser #(.NUM_DIGITS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_digit     (in_digit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bcd      (out_bcd),
        .out_err      (out_err),
        .out_err_mask (out_err_mask)
    );

    always #5 clk = ~clk;

    // {illegal, bcd}: legal Excess-3 is value+3 for decimal 0..9
    function automatic logic [4:0] ref_decode(input logic [3:0] c);
        int v;
        v = int'(c) - 3;
        if (v >= 0 && v <= 9) return {1'b0, 4'(v)};
        return {1'b1, 4'hF};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        exp_hold = 1'b0;
        acc_q.delete();
    endtask

    task automatic model_edge(input logic iv, input logic [3:0] d, input logic ordy);
        logic [4:0] r;
        if (exp_hold) begin
            if (ordy) exp_hold = 1'b0;
        end else if (iv) begin
            acc_q.push_back(d);
            if (acc_q.size() == N) begin
                exp_bcd  = '0;
                exp_mask = '0;
                for (int k = 0; k < N; k++) begin
                    r = ref_decode(acc_q[k]);
                    exp_bcd = {exp_bcd[4*N-5:0], r[3:0]};
                    exp_mask[N-1-k] = r[4];
                end
                exp_hold = 1'b1;
                acc_q.delete();
            end
        end
    endtask

    task automatic check_state();
        chk("in_ready", 32'(in_ready), 32'(!exp_hold));
        chk("out_valid", 32'(out_valid), 32'(exp_hold));
        if (exp_hold) begin
            chk("out_bcd", 32'(out_bcd), 32'(exp_bcd));
            chk("out_err_mask", 32'(out_err_mask), 32'(exp_mask));
            chk("out_err", 32'(out_err), 32'(|exp_mask));
        end
    endtask

    // Called at a negedge; drives one cycle and checks after the next posedge.
    task automatic step(input logic iv, input logic [3:0] d, input logic ordy);
        in_valid  = iv;
        in_digit  = d;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, d, ordy);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_digit  = 4'h7;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        model_clear();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_mask", 32'(out_err_mask), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digit  = 4'h0;
        out_ready = 1'b0;
        model_clear();
        do_reset();

        // Word 1: back-to-back digits, out_valid for exactly one cycle
        step(1, 4'h4, 1); step(1, 4'h8, 1); step(1, 4'hC, 1); step(1, 4'h3, 1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_bcd", 32'(out_bcd), 32'h1590);
        chk("t1_err", 32'(out_err), 32'd0);
        step(0, 4'h0, 1);
        chk("t1_one_cycle", 32'(out_valid), 32'd0);

        // Word 2: illegal codes in nibbles 2 and 0
        step(1, 4'h3, 1); step(1, 4'h0, 1); step(1, 4'h6, 1); step(1, 4'hD, 0);
        chk("t2_bcd", 32'(out_bcd), 32'h0F3F);
        chk("t2_mask", 32'(out_err_mask), 32'b0101);
        chk("t2_err", 32'(out_err), 32'd1);
        step(0, 4'h0, 1);

        // Word 3: back-pressure with ignored input pulses
        step(1, 4'h5, 0); step(1, 4'h6, 0); step(1, 4'h7, 0); step(1, 4'h8, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 4'h9, 0);
            chk("t3_hold_bcd", 32'(out_bcd), 32'h2345);
            chk("t3_hold_ready", 32'(in_ready), 32'd0);
        end
        step(0, 4'h0, 1);
        chk("t3_release", 32'(in_ready), 32'd1);

        // Word 4: reset discards a partial word
        step(1, 4'h9, 1); step(1, 4'h9, 1);
        do_reset();
        step(1, 4'h4, 1); step(1, 4'h4, 1); step(1, 4'h4, 1); step(1, 4'h4, 0);
        chk("t4_bcd", 32'(out_bcd), 32'h1111);
        step(0, 4'h0, 1);

        // Word 5: input gaps
        step(1, 4'hC, 0); step(0, 4'h1, 0); step(0, 4'h2, 0); step(1, 4'hB, 0);
        step(0, 4'h0, 0); step(1, 4'hA, 0); step(1, 4'h9, 0);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_bcd", 32'(out_bcd), 32'h9876);
        step(0, 4'h0, 1);

        // Sweep all 16 codes over four words
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) step(1, 4'(w*4 + k), 0);
            case (w)
                0: begin chk("sw0_bcd", 32'(out_bcd), 32'hFFF0); chk("sw0_mask", 32'(out_err_mask), 32'b1110); end
                1: begin chk("sw1_bcd", 32'(out_bcd), 32'h1234); chk("sw1_mask", 32'(out_err_mask), 32'b0000); end
                2: begin chk("sw2_bcd", 32'(out_bcd), 32'h5678); chk("sw2_mask", 32'(out_err_mask), 32'b0000); end
                default: begin chk("sw3_bcd", 32'(out_bcd), 32'h9FFF); chk("sw3_mask", 32'(out_err_mask), 32'b0111); end
            endcase
            step(0, 4'h0, 1);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     logic'($urandom_range(0, 2) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
